// File: rtl/bus_arbiter.sv
// Registered fixed-priority shared-bus arbiter with bus locking and conflict counting.
// Optional macro BUS_KEEPER_EN: hold the last bus value when nothing drives instead of 0.
module bus_arbiter #(
  parameter int WIDTH = 8,
  parameter int N_SRC = 5,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_SRC-1:0]       src_en,
  input  logic [N_SRC-1:0]       src_lock,
  input  logic [N_SRC*WIDTH-1:0] src_data,
  input  logic                   err_clr,
  output logic [WIDTH-1:0]       bus,
  output logic [N_SRC-1:0]       grant,
  output logic                   bus_valid,
  output logic                   conflict,
  output logic [CNT_W-1:0]       conflict_cnt,
  output logic                   err_sticky
);

  localparam int OWN_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t           state;
  logic [OWN_W-1:0] owner;

  logic             owner_hold;
  logic             have_win;
  logic             win_lock;
  logic             conflict_now;
  logic [OWN_W-1:0] win_idx;
  logic [WIDTH-1:0] win_data;
  logic [N_SRC-1:0] win_onehot;

  always_comb begin
    owner_hold = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (state == OWNED && owner == OWN_W'(i) && src_en[i] && src_lock[i])
        owner_hold = 1'b1;
    end

    have_win = 1'b0;
    win_idx  = '0;
    if (owner_hold) begin
      have_win = 1'b1;
      win_idx  = owner;
    end else begin
      // Descending scan so the lowest requesting index is the last to assign.
      for (int i = N_SRC - 1; i >= 0; i--) begin
        if (src_en[i]) begin
          have_win = 1'b1;
          win_idx  = OWN_W'(i);
        end
      end
    end

    win_lock   = 1'b0;
    win_data   = '0;
    win_onehot = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (have_win && win_idx == OWN_W'(i)) begin
        win_lock      = src_lock[i];
        win_data      = src_data[i*WIDTH +: WIDTH];
        win_onehot[i] = 1'b1;
      end
    end

    // Two or more bits set iff clearing the lowest set bit leaves something.
    conflict_now = |(src_en & (src_en - N_SRC'(1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= '0;
      bus          <= '0;
      grant        <= '0;
      bus_valid    <= 1'b0;
      conflict     <= 1'b0;
      conflict_cnt <= '0;
      err_sticky   <= 1'b0;
    end else begin
      conflict <= conflict_now;
      if (err_clr) begin
        conflict_cnt <= '0;
        err_sticky   <= 1'b0;
      end else if (conflict_now) begin
        err_sticky <= 1'b1;
        if (conflict_cnt != '1)
          conflict_cnt <= conflict_cnt + CNT_W'(1);
      end

      if (have_win) begin
        bus       <= win_data;
        grant     <= win_onehot;
        bus_valid <= 1'b1;
        if (win_lock) begin
          state <= OWNED;
          owner <= win_idx;
        end else begin
          state <= IDLE;
        end
      end else begin
        grant     <= '0;
        bus_valid <= 1'b0;
        state     <= IDLE;
`ifdef BUS_KEEPER_EN
        bus <= bus;
`else
        bus <= '0;
`endif
      end
    end
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Parametrised, registered successor to the SAP shared-bus multiplexer. It selects one of `N_SRC` drivers by fixed priority, lowest index first, and registers the winner's data onto the bus. A driver can lock the bus for multi-cycle transfers. Simultaneous drive attempts are detected and counted. It sits between the SAP datapath sources (IR, adder, A, memory, PC, …) and all bus consumers.

## Interface
Parameters:
- `WIDTH`, 8, bus data width in bits.
- `N_SRC`, 5, number of bus sources. Must be at least 2.
- `CNT_W`, 8, width of the conflict counter.

Ports:
- `clk`  input  1  system clock. Every register updates on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `src_en`  input  N_SRC  per-source drive request.
- `src_lock`  input  N_SRC  per-source lock request. Meaningful only together with the matching `src_en` bit.
- `src_data`  input  N_SRC*WIDTH  flattened source data. Source i occupies bits [i*WIDTH +: WIDTH].
- `err_clr`  input  1  clears `conflict_cnt` and `err_sticky`.
- `bus`  output  WIDTH  registered bus value.
- `grant`  output  N_SRC  registered one-hot grant. All zeros when no source is driving.
- `bus_valid`  output  1  registered. High when `bus` carries a granted source's data.
- `conflict`  output  1  registered one-cycle pulse.
- `conflict_cnt`  output  CNT_W  saturating count of conflict cycles.
- `err_sticky`  output  1  set by any conflict. Held until cleared.

## Operation
- Winner selection:
  - IDLE: winner = lowest index i with `src_en[i]`=1.
  - OWNED: winner = owner o, as long as `src_en[o]`=1 and `src_lock[o]`=1. Lower-index requests are ignored while this holds.
- State machine, states IDLE and OWNED, with registered owner index:
  - IDLE→OWNED when the selected winner has `src_lock`=1. The owner index is captured.
  - OWNED→IDLE when the owner drops `src_en` or `src_lock`. In that same cycle, selection uses the IDLE rule.
  - A new winner with `src_lock`=1 re-enters OWNED immediately.
- Registered outputs on each edge:
  - With a winner w: `bus` ← data of w; `grant` ← one-hot(w); `bus_valid` ← 1.
  - With no winner: `grant` ← 0 and `bus_valid` ← 0. `bus` follows the Configuration section.
- Conflict detection:
  - A conflict is any cycle with popcount(`src_en`) ≥ 2, whatever the state.
  - On a conflict: `conflict` ← 1 on the next edge; `conflict_cnt` increments, saturating at 2^CNT_W−1; `err_sticky` ← 1.
  - Otherwise `conflict` ← 0.
- `err_clr`:
  - Clears `conflict_cnt` and `err_sticky` on the next edge.
  - If a conflict occurs in the same cycle, clear wins: counter = 0, sticky = 0. The `conflict` pulse is still generated.
- Arithmetic: the counter is unsigned CNT_W bits and never wraps.

## Timing
- Latency is 1 cycle from `src_en`/`src_data`/`src_lock` to `bus`/`grant`/`bus_valid`. There is no combinational input-to-output path.
- `conflict` has 1-cycle latency. `conflict_cnt` and `err_sticky` update on the same edge as `conflict`.
- Reset values: `bus`=0, `grant`=0, `bus_valid`=0, `conflict`=0, `conflict_cnt`=0, `err_sticky`=0, state = IDLE, owner = 0.
- Reset asserted mid-lock returns to IDLE and drops the lock. The first edge after reset deasserts arbitrates by the IDLE rule.
- `rst` has priority over `err_clr` and all inputs.
- Data of a locked owner may change every cycle. Each change appears on `bus` one cycle later.

## Configuration
- Macro `BUS_KEEPER_EN`:
  - Defined: with no winner, `bus` holds its previous registered value and `bus_valid`=0.
  - Undefined: with no winner, `bus` ← 0, matching the legacy bus default.
  - Reset value of `bus` is 0 in both builds.

## Test plan
All scenarios use N_SRC=5, WIDTH=8, CNT_W=8.
- **Priority:** `src_en`=5'b10100, data2=8'h3C, data4=8'hA5 → next cycle `bus`=8'h3C, `grant`=5'b00100, `bus_valid`=1, `conflict`=1, `conflict_cnt`=1, `err_sticky`=1.
- **Lock:** source 3 asserts en+lock with data 8'h11 for 4 cycles; source 0 asserts en (data 8'h77) from cycle 2 → `bus`=8'h11 and `grant`=5'b01000 for all 4 cycles. When source 3 drops lock → next cycle `bus`=8'h77, `grant`=5'b00001.
- **Idle bus:** `src_en`=0 after `bus`=8'h5A → `grant`=0, `bus_valid`=0. `bus`=8'h00 without `BUS_KEEPER_EN`; `bus`=8'h5A with it.
- **Saturation and clear:** 300 consecutive conflict cycles → `conflict_cnt`=8'hFF. Then `err_clr`=1 in the same cycle as a conflict → `conflict_cnt`=0, `err_sticky`=0, `conflict`=1.
- **Reset mid-lock:** source 1 locked with `bus`=8'h42, then `rst`=1 for one cycle → all outputs 0 and state IDLE. Source 0 requesting after reset is granted next cycle.
